// File: rtl/amo_sequencer_pkg.sv
// Shared types for the RV32A atomic sequencer: op selects, FSM states, reservation.
// Optional store/DMA snoop of the reservation is enabled with AMO_STORE_SNOOP_EN.
package amo_sequencer_pkg;

  localparam int unsigned XLEN_P     = 32;
  localparam int unsigned ADDR_W_P   = 32;
  localparam int unsigned RSV_LOG2_P = 2;
  localparam int unsigned TAG_W      = ADDR_W_P - RSV_LOG2_P;

  typedef enum logic [3:0] {
    ASEL_LR       = 4'd0,
    ASEL_SC       = 4'd1,
    ASEL_AMO_SWAP = 4'd2,
    ASEL_AMO_ADD  = 4'd3,
    ASEL_AMO_XOR  = 4'd4,
    ASEL_AMO_AND  = 4'd5,
    ASEL_AMO_OR   = 4'd6,
    ASEL_AMO_MIN  = 4'd7,
    ASEL_AMO_MAX  = 4'd8
  } AextSel;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5
  } AmoState;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } Reservation;

endpackage

// File: rtl/amo_sequencer_alu.sv
// Combinational AMO read-modify-write function: new value from old memory word and rs2.
module amo_alu
  import amo_sequencer_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_P
) (
  input  AextSel            asel,
  input  logic              is_unsigned,
  input  logic [XLEN-1:0]   old,
  input  logic [XLEN-1:0]   rs2,
  output logic [XLEN-1:0]   new_val_c
);

  logic lt_c;
  logic gt_c;

  // Strict compares so a tie keeps the old value
  always_comb begin
    if (is_unsigned) begin
      lt_c = rs2 < old;
      gt_c = rs2 > old;
    end else begin
      lt_c = $signed(rs2) < $signed(old);
      gt_c = $signed(rs2) > $signed(old);
    end
  end

  always_comb begin
    new_val_c = rs2;
    case (asel)
      ASEL_AMO_SWAP: new_val_c = rs2;
      ASEL_AMO_ADD:  new_val_c = old + rs2;
      ASEL_AMO_XOR:  new_val_c = old ^ rs2;
      ASEL_AMO_AND:  new_val_c = old & rs2;
      ASEL_AMO_OR:   new_val_c = old | rs2;
      ASEL_AMO_MIN:  new_val_c = lt_c ? rs2 : old;
      ASEL_AMO_MAX:  new_val_c = gt_c ? rs2 : old;
      default:       new_val_c = rs2;
    endcase
  end

endmodule

// File: rtl/amo_sequencer.sv
// RV32A sequencer: LR/SC reservation plus AMO read-modify-write over the data-memory port.
// Define AMO_STORE_SNOOP_EN to add snoop_valid/snoop_addr reservation invalidation.
module amo_sequencer
  import amo_sequencer_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_P,
  parameter int unsigned ADDR_W   = ADDR_W_P,
  parameter int unsigned RSV_LOG2 = RSV_LOG2_P
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  AextSel            req_asel,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              clear_rsv,
`ifdef AMO_STORE_SNOOP_EN
  input  logic              snoop_valid,
  input  logic [ADDR_W-1:0] snoop_addr,
`endif
  output logic              rsv_valid
);

  AmoState          state;
  Reservation       rsv;
  AextSel           asel_q;
  logic             uns_q;
  logic [XLEN-1:0]  wdata_q;
  logic [XLEN-1:0]  result_q;
  logic [TAG_W-1:0] tag_q;
  logic [TAG_W-1:0] req_tag_c;
  logic [XLEN-1:0]  alu_new_c;
  logic             clear_c;
  logic             sc_ok_c;

  assign req_tag_c = TAG_W'(req_addr >> RSV_LOG2);

`ifdef AMO_STORE_SNOOP_EN
  assign clear_c = clear_rsv ||
                   (snoop_valid && rsv.valid && (TAG_W'(snoop_addr >> RSV_LOG2) == rsv.tag));
`else
  assign clear_c = clear_rsv;
`endif

  // A same-cycle clear beats a matching SC
  assign sc_ok_c   = rsv.valid && !clear_c && (req_tag_c == rsv.tag);
  assign rsv_valid = rsv.valid;

  amo_alu #(.XLEN(XLEN)) u_alu (
    .asel        (asel_q),
    .is_unsigned (uns_q),
    .old         (mem_rdata),
    .rs2         (wdata_q),
    .new_val_c   (alu_new_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rsv        <= '0;
      asel_q     <= ASEL_LR;
      uns_q      <= 1'b0;
      wdata_q    <= '0;
      result_q   <= '0;
      tag_q      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      mem_valid  <= 1'b0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      // Later assignments below (LR set) take priority over this clear
      if (clear_c) rsv.valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            asel_q    <= req_asel;
            uns_q     <= req_unsigned;
            wdata_q   <= req_wdata;
            tag_q     <= req_tag_c;
            req_ready <= 1'b0;
            mem_addr  <= req_addr & ~ADDR_W'(3);
            if (req_asel == ASEL_SC) begin
              rsv.valid <= 1'b0;
              if (sc_ok_c) begin
                state     <= WR_REQ;
                mem_valid <= 1'b1;
                mem_wen   <= 1'b1;
                mem_wdata <= req_wdata;
              end else begin
                state      <= DONE;
                resp_valid <= 1'b1;
                resp_data  <= XLEN'(1);
              end
            end else begin
              state     <= RD_REQ;
              mem_valid <= 1'b1;
              mem_wen   <= 1'b0;
            end
          end
        end
        RD_REQ: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (mem_rvalid) begin
            result_q <= mem_rdata;
            if (asel_q == ASEL_LR) begin
              rsv        <= '{valid: 1'b1, tag: tag_q};
              resp_valid <= 1'b1;
              resp_data  <= mem_rdata;
              state      <= DONE;
            end else begin
              mem_wdata <= alu_new_c;
              mem_valid <= 1'b1;
              mem_wen   <= 1'b1;
              state     <= WR_REQ;
            end
          end
        end
        WR_REQ: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (mem_rvalid) begin
            resp_valid <= 1'b1;
            resp_data  <= (asel_q == ASEL_SC) ? '0 : result_q;
            state      <= DONE;
          end
        end
        DONE: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_amo_sequencer.sv
// Self-checking bench for amo_sequencer: AMO vector table plus LR/SC, stall and reset sequences.
module tb_amo_sequencer;
  import amo_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  AextSel      req_asel;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        clear_rsv;
  logic        rsv_valid;

  always #5 clk = ~clk;

  amo_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_asel     (req_asel),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .clear_rsv    (clear_rsv),
    .rsv_valid    (rsv_valid)
  );

  // Memory model: evaluated on the falling edge, responds the cycle after acceptance
  logic [31:0] mem [0:255];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          unstable = 0;
  int          misaligned = 0;
  int          stall_cfg = 0;
  int          stall_left = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_data = '0;
  logic        inject = 1'b0;
  logic        have_prev = 1'b0;
  logic [31:0] p_addr, p_wdata;
  logic        p_wen;

  initial begin
    mem_ready  = 1'b1;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    p_addr = '0; p_wdata = '0; p_wen = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
  end

  always @(negedge clk) begin
    mem_rvalid = pend;
    mem_rdata  = pend_data;
    pend       = 1'b0;
    if (inject) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBAD0BAD0;
      inject     = 1'b0;
    end
    if (mem_valid) begin
      if (have_prev && !(mem_addr == p_addr && mem_wen == p_wen && (!mem_wen || mem_wdata == p_wdata)))
        unstable++;
      if (mem_addr[1:0] != 2'b00) misaligned++;
      if (stall_left > 0) begin
        mem_ready = 1'b0;
        stall_left--;
        have_prev = 1'b1;
        p_addr = mem_addr; p_wen = mem_wen; p_wdata = mem_wdata;
      end else begin
        mem_ready  = 1'b1;
        have_prev  = 1'b0;
        stall_left = stall_cfg;
        if (mem_wen) begin
          mem[mem_addr[9:2]] = mem_wdata;
          wr_cnt++;
        end else begin
          pend_data = mem[mem_addr[9:2]];
          rd_cnt++;
        end
        pend = 1'b1;
      end
    end else begin
      mem_ready = 1'b1;
      have_prev = 1'b0;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Issue one op; clr_at selects the cycle (0 = accept) on which clear_rsv pulses
  task automatic issue(input AextSel a, input logic u, input logic [31:0] addr,
                       input logic [31:0] rs2, input int clr_at,
                       output int lat, output logic [31:0] data, output logic pulse_ok);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1; req_asel = a; req_unsigned = u; req_addr = addr; req_wdata = rs2;
    clear_rsv = (clr_at == 0);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    clear_rsv = (clr_at == 1);
    while (!resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
      clear_rsv = (clr_at == lat);
    end
    clear_rsv = 1'b0;
    if (!resp_valid) lat = -1;
    data = resp_data;
    @(negedge clk);
    pulse_ok = !resp_valid;
  endtask

  typedef struct packed {
    AextSel      asel;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] init;
    logic [31:0] rs2;
    logic [31:0] exp_mem;
    logic [31:0] exp_resp;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int          lat;
    logic [31:0] data;
    logic        pok;
    int          rd0, wr0, seen;

    vecs[0]  = '{ASEL_AMO_ADD,  1'b0, 32'h100, 32'd5,        32'd7,        32'd12,       32'd5};
    vecs[1]  = '{ASEL_AMO_SWAP, 1'b0, 32'h104, 32'hDEADBEEF, 32'h12345678, 32'h12345678, 32'hDEADBEEF};
    vecs[2]  = '{ASEL_AMO_XOR,  1'b0, 32'h108, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0};
    vecs[3]  = '{ASEL_AMO_AND,  1'b0, 32'h10C, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'hF0F0F0F0};
    vecs[4]  = '{ASEL_AMO_OR,   1'b0, 32'h110, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 32'hF0F0F0F0};
    vecs[5]  = '{ASEL_AMO_MIN,  1'b0, 32'h114, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[6]  = '{ASEL_AMO_MIN,  1'b1, 32'h118, 32'hFFFFFFFF, 32'd1,        32'd1,        32'hFFFFFFFF};
    vecs[7]  = '{ASEL_AMO_MAX,  1'b0, 32'h11C, 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000};
    vecs[8]  = '{ASEL_AMO_MAX,  1'b1, 32'h120, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h80000000};
    vecs[9]  = '{ASEL_AMO_ADD,  1'b0, 32'h124, 32'hFFFFFFFF, 32'd2,        32'd1,        32'hFFFFFFFF};
    vecs[10] = '{ASEL_AMO_MAX,  1'b0, 32'h128, 32'hFFFFFFF0, 32'h00000005, 32'h00000005, 32'hFFFFFFF0};
    vecs[11] = '{ASEL_AMO_ADD,  1'b0, 32'h12F, 32'd3,        32'd4,        32'd7,        32'd3};

    reset = 1'b1; req_valid = 1'b0; req_asel = ASEL_LR; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; clear_rsv = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready",  32'(req_ready),  32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data",  resp_data,       32'd0);
    check("rst_mem_valid",  32'(mem_valid),  32'd0);
    check("rst_mem_wen",    32'(mem_wen),    32'd0);
    check("rst_mem_addr",   mem_addr,        32'd0);
    check("rst_mem_wdata",  mem_wdata,       32'd0);
    check("rst_rsv_valid",  32'(rsv_valid),  32'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      mem[vecs[i].addr[9:2]] = vecs[i].init;
      rd0 = rd_cnt; wr0 = wr_cnt;
      issue(vecs[i].asel, vecs[i].uns, vecs[i].addr, vecs[i].rs2, -1, lat, data, pok);
      check($sformatf("v%0d_resp", i),  data,                        vecs[i].exp_resp);
      check($sformatf("v%0d_mem", i),   mem[vecs[i].addr[9:2]],      vecs[i].exp_mem);
      check($sformatf("v%0d_lat", i),   32'(lat),                    32'd5);
      check($sformatf("v%0d_rdwr", i),  32'((rd_cnt - rd0) * 16 + (wr_cnt - wr0)), 32'h11);
      check($sformatf("v%0d_pulse", i), 32'(pok),                    32'd1);
    end

    // LR then matching SC
    mem[8'h80] = 32'h55;
    issue(ASEL_LR, 1'b0, 32'h200, 32'h0, -1, lat, data, pok);
    check("lr_resp", data, 32'h55);
    check("lr_lat",  32'(lat), 32'd3);
    check("lr_rsv",  32'(rsv_valid), 32'd1);
    wr0 = wr_cnt;
    issue(ASEL_SC, 1'b0, 32'h200, 32'hAB, -1, lat, data, pok);
    check("sc_ok_resp", data, 32'd0);
    check("sc_ok_lat",  32'(lat), 32'd3);
    check("sc_ok_mem",  mem[8'h80], 32'hAB);
    check("sc_ok_wr",   32'(wr_cnt - wr0), 32'd1);
    check("sc_ok_rsv",  32'(rsv_valid), 32'd0);

    // SC without reservation
    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(ASEL_SC, 1'b0, 32'h200, 32'hCD, -1, lat, data, pok);
    check("sc_none_resp", data, 32'd1);
    check("sc_none_lat",  32'(lat), 32'd1);
    check("sc_none_mem",  32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);
    check("sc_none_val",  mem[8'h80], 32'hAB);

    // SC to a different granule fails and still drops the reservation
    issue(ASEL_LR, 1'b0, 32'h200, 32'h0, -1, lat, data, pok);
    mem[8'h81] = 32'h1234;
    wr0 = wr_cnt;
    issue(ASEL_SC, 1'b0, 32'h204, 32'h77, -1, lat, data, pok);
    check("sc_miss_resp", data, 32'd1);
    check("sc_miss_lat",  32'(lat), 32'd1);
    check("sc_miss_wr",   32'(wr_cnt - wr0), 32'd0);
    check("sc_miss_mem",  mem[8'h81], 32'h1234);
    check("sc_miss_rsv",  32'(rsv_valid), 32'd0);

    // LR overwrite: newer LR moves the reservation
    issue(ASEL_LR, 1'b0, 32'h300, 32'h0, -1, lat, data, pok);
    issue(ASEL_LR, 1'b0, 32'h208, 32'h0, -1, lat, data, pok);
    issue(ASEL_SC, 1'b0, 32'h300, 32'h99, -1, lat, data, pok);
    check("lr_ovw_resp", data, 32'd1);

    // clear_rsv on the SC accept cycle
    issue(ASEL_LR, 1'b0, 32'h200, 32'h0, -1, lat, data, pok);
    issue(ASEL_SC, 1'b0, 32'h200, 32'h66, 0, lat, data, pok);
    check("sc_clr_resp", data, 32'd1);
    check("sc_clr_mem",  mem[8'h80], 32'hAB);

    // clear_rsv during LR completion: LR's set wins
    issue(ASEL_LR, 1'b0, 32'h200, 32'h0, 2, lat, data, pok);
    check("lr_clr_rsv", 32'(rsv_valid), 32'd1);
    @(negedge clk); clear_rsv = 1'b1;
    @(negedge clk); clear_rsv = 1'b0;
    check("idle_clr_rsv", 32'(rsv_valid), 32'd0);

    // Four-cycle mem_ready stall on both read and write
    stall_cfg = 4; stall_left = 4;
    mem[8'h4A] = 32'd10;
    rd0 = rd_cnt; wr0 = wr_cnt; unstable = 0;
    issue(ASEL_AMO_ADD, 1'b0, 32'h128, 32'd20, -1, lat, data, pok);
    stall_cfg = 0; stall_left = 0;
    check("stall_resp",   data, 32'd10);
    check("stall_mem",    mem[8'h4A], 32'd30);
    check("stall_lat",    32'(lat), 32'd13);
    check("stall_rdwr",   32'((rd_cnt - rd0) * 16 + (wr_cnt - wr0)), 32'h11);
    check("stall_stable", 32'(unstable), 32'd0);

    // Reset while in WR_WAIT, then a stray late response
    mem[8'h90] = 32'd1;
    @(negedge clk);
    req_valid = 1'b1; req_asel = ASEL_AMO_ADD; req_unsigned = 1'b0;
    req_addr = 32'h240; req_wdata = 32'd1;
    @(negedge clk); req_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_ready", 32'(req_ready),  32'd1);
    check("mid_rst_resp",  32'(resp_valid), 32'd0);
    check("mid_rst_mval",  32'(mem_valid),  32'd0);
    inject = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid || mem_valid || !req_ready) seen++;
    end
    check("late_rvalid_ignored", 32'(seen), 32'd0);
    check("late_resp_data", resp_data, 32'd0);

    mem[8'h91] = 32'd40;
    issue(ASEL_AMO_ADD, 1'b0, 32'h244, 32'd2, -1, lat, data, pok);
    check("post_rst_resp", data, 32'd40);
    check("post_rst_mem",  mem[8'h91], 32'd42);
    check("misaligned",    32'(misaligned), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
